nco_out_serializer: RTL and testbench

Upstream feeder for the NCO output terminal. Accepts one parallel 12-bit X/Y sample pair plus an invert-sign flag from the NCO core over a valid/ready handshake. Buffers one pending sample. Emits a one-cycle Rdy strobe, then streams each word as six 2-bit dibits, LSB first, on the narrow Xin/Yin pad bus. Waits for the terminal's Vld acknowledge before starting the next frame.

---
 rtl/nco_out_serializer_if.sv | 26 ++
 rtl/nco_out_serializer.sv | 140 ++++++++++++++
 tb/tb_nco_out_serializer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_out_serializer_if.sv
// Bus between the NCO core, nco_out_serializer and the output terminal.
// Valid/ready: a sample moves on a rising edge where inValid && inReady; inReady never depends on inValid.
interface nco_out_serializer_if;
  logic        inValid;
  logic        inReady;
  logic [11:0] Xpar;
  logic [11:0] Ypar;
  logic        inInv;
  logic        Rdy;
  logic [1:0]  Xout;
  logic [1:0]  Yout;
  logic        ISout;
  logic        VldIn;
  logic        Ovf;
  logic        AckErr;

  modport master (
    output inValid, Xpar, Ypar, inInv, VldIn,
    input  inReady, Rdy, Xout, Yout, ISout, Ovf, AckErr
  );

  modport slave (
    input  inValid, Xpar, Ypar, inInv, VldIn,
    output inReady, Rdy, Xout, Yout, ISout, Ovf, AckErr
  );
endinterface

// File: rtl/nco_out_serializer.sv
// NCO output serializer: one-entry sample buffer feeding a Rdy strobe plus six LSB-first dibits per word.
// Optional macro NCO_SER_OVERWRITE_EN: no backpressure, a new sample overwrites the buffer and sets Ovf.
module nco_out_serializer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nco_out_serializer_if.slave        bus,
  output logic [1:0]                 dbg_state
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    SHIFT    = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST   = 8'(ACK_TIMEOUT - 1);
  localparam logic [2:0] LAST_DIBIT = 3'd5;

  state_t      state_q, state_d;
  logic        buf_full;
  logic [11:0] buf_x, buf_y;
  logic        buf_inv;
  logic [11:0] sh_x, sh_y;
  logic        is_q;
  logic [1:0]  xout_q, yout_q;
  logic [2:0]  cnt_q;
  logic [7:0]  tmo_q;
  logic        ackerr_q;
  logic        accept, pop, tmo_abort, shifting;

`ifdef NCO_SER_OVERWRITE_EN
  assign bus.inReady = rst_n;
`else
  assign bus.inReady = rst_n & ~buf_full;
`endif

  assign accept   = bus.inValid & bus.inReady;
  // Cycles whose following cycle presents a data dibit: START and SHIFT k=0..4.
  assign shifting = (state_q == START) || ((state_q == SHIFT) && (cnt_q != LAST_DIBIT));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    tmo_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_full) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START:   state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_DIBIT) state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.VldIn) begin
          if (buf_full) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_abort = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_x    <= '0;
      buf_y    <= '0;
      buf_inv  <= 1'b0;
      sh_x     <= '0;
      sh_y     <= '0;
      is_q     <= 1'b0;
      xout_q   <= '0;
      yout_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      ackerr_q <= 1'b0;
    end else begin
      if (accept) begin
        buf_x   <= bus.Xpar;
        buf_y   <= bus.Ypar;
        buf_inv <= bus.inInv;
      end
      buf_full <= accept | (buf_full & ~pop);

      // The shifter belongs to the frame in flight; only a pop reloads it.
      if (pop) begin
        sh_x <= buf_x;
        sh_y <= buf_y;
        is_q <= buf_inv;
      end else if (shifting) begin
        sh_x <= {2'b00, sh_x[11:2]};
        sh_y <= {2'b00, sh_y[11:2]};
      end

      xout_q <= shifting ? sh_x[1:0] : 2'b00;
      yout_q <= shifting ? sh_y[1:0] : 2'b00;

      cnt_q <= (state_q == SHIFT)    ? cnt_q + 3'd1 : 3'd0;
      tmo_q <= (state_q == WAIT_ACK) ? tmo_q + 8'd1 : 8'd0;

      if (tmo_abort) ackerr_q <= 1'b1;
    end
  end

`ifdef NCO_SER_OVERWRITE_EN
  logic ovf_q;

  // Accepting into a full buffer that is being popped the same cycle is a normal refill.
  always_ff @(posedge clk) begin
    if (!rst_n)                        ovf_q <= 1'b0;
    else if (accept & buf_full & ~pop) ovf_q <= 1'b1;
  end

  assign bus.Ovf = ovf_q;
`else
  assign bus.Ovf = 1'b0;
`endif

  assign bus.Rdy    = (state_q == START);
  assign bus.Xout   = xout_q;
  assign bus.Yout   = yout_q;
  assign bus.ISout  = is_q;
  assign bus.AckErr = ackerr_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_nco_out_serializer.sv
// Directed bench for nco_out_serializer: vector table for whole frames plus hand sequences for
// ack timeout, reset mid-frame and buffer overwrite/backpressure.
module tb_nco_out_serializer;
  localparam int ACK_TIMEOUT = 15;
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_SHIFT = 2'd2, S_WAIT = 2'd3;
`ifdef NCO_SER_OVERWRITE_EN
  localparam logic OW = 1'b1;
`else
  localparam logic OW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  nco_out_serializer_if bus();

  nco_out_serializer #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] exp_q[$];
  logic [11:0] acc_x, acc_y;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] x, input logic [11:0] y,
                       input logic inv, input logic ack);
    bus.inValid = v;
    bus.Xpar    = x;
    bus.Ypar    = y;
    bus.inInv   = inv;
    bus.VldIn   = ack;
  endtask

  typedef struct {
    logic        v;
    logic [11:0] x;
    logic [11:0] y;
    logic        inv;
    logic        ack;
    logic        e_rin;
    logic        e_rdy;
    logic [1:0]  e_x;
    logic [1:0]  e_y;
    logic        e_is;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [11:0] x, input logic [11:0] y, input logic inv,
                     input logic ack, input logic e_rin, input logic e_rdy, input logic [1:0] e_x,
                     input logic [1:0] e_y, input logic e_is, input logic [1:0] e_st);
    vec_t r;
    r.v = v; r.x = x; r.y = y; r.inv = inv; r.ack = ack;
    r.e_rin = e_rin; r.e_rdy = e_rdy; r.e_x = e_x; r.e_y = e_y; r.e_is = e_is; r.e_st = e_st;
    vecs.push_back(r);
  endtask

  // SHIFT row with idle inputs
  task automatic add_sh(input logic [1:0] e_x, input logic [1:0] e_y, input logic e_rin, input logic e_is);
    add(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, e_rin, 1'b0, e_x, e_y, e_is, S_SHIFT);
  endtask

  logic [23:0] ew;
  logic [24:0] pend_q[$];

  initial begin
    // Frame 1: X=ABC Y=123 inv=0, ack at relative cycle 7
    add(1'b1, 12'hABC, 12'h123, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, S_IDLE);
    add(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, S_IDLE);
    add(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, S_START);
    add_sh(2'd0, 2'd3, 1'b1, 1'b0);
    add_sh(2'd3, 2'd0, 1'b1, 1'b0);
    add_sh(2'd3, 2'd2, 1'b1, 1'b0);
    add_sh(2'd2, 2'd0, 1'b1, 1'b0);
    add_sh(2'd2, 2'd1, 1'b1, 1'b0);
    add_sh(2'd2, 2'd0, 1'b1, 1'b0);
    add(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, S_WAIT);
    add(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, S_IDLE);
    // Back-to-back: A=5A5/3C3 inv0, B=001/FFF inv1 stalled one cycle, second Rdy 8 cycles later
    add(1'b1, 12'h5A5, 12'h3C3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, S_IDLE);
    add(1'b1, 12'h001, 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, S_IDLE);
    add(1'b1, 12'h001, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, S_START);
    add_sh(2'd1, 2'd3, 1'b0, 1'b0);
    add_sh(2'd1, 2'd0, 1'b0, 1'b0);
    add_sh(2'd2, 2'd0, 1'b0, 1'b0);
    add_sh(2'd2, 2'd3, 1'b0, 1'b0);
    add_sh(2'd1, 2'd3, 1'b0, 1'b0);
    add_sh(2'd1, 2'd0, 1'b0, 1'b0);
    add(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, S_WAIT);
    add(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, S_START);
    add_sh(2'd1, 2'd3, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) add_sh(2'd0, 2'd3, 1'b1, 1'b1);
    add(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, S_WAIT);
    add(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, S_IDLE);

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    check("rst_inready", 32'(bus.inReady), 0);
    check("rst_rdy", 32'(bus.Rdy), 0);
    check("rst_xout", 32'(bus.Xout), 0);
    check("rst_yout", 32'(bus.Yout), 0);
    check("rst_isout", 32'(bus.ISout), 0);
    check("rst_ovf", 32'(bus.Ovf), 0);
    check("rst_ackerr", 32'(bus.AckErr), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    rst_n = 1'b1;

    // ---------------- vector table ----------------
    acc_x = '0;
    acc_y = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].inv, vecs[i].ack);
      @(negedge clk);
      check($sformatf("vec%0d_inready", i), 32'(bus.inReady), 32'(vecs[i].e_rin));
      check($sformatf("vec%0d_rdy", i), 32'(bus.Rdy), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_xout", i), 32'(bus.Xout), 32'(vecs[i].e_x));
      check($sformatf("vec%0d_yout", i), 32'(bus.Yout), 32'(vecs[i].e_y));
      check($sformatf("vec%0d_isout", i), 32'(bus.ISout), 32'(vecs[i].e_is));
      check($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_st));
      if (vecs[i].v && vecs[i].e_rin) exp_q.push_back({vecs[i].x, vecs[i].y});
      if (vecs[i].e_st == S_SHIFT) begin
        acc_x = {bus.Xout, acc_x[11:2]};
        acc_y = {bus.Yout, acc_y[11:2]};
      end
      if (vecs[i].ack && vecs[i].e_st == S_WAIT) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL vec%0d_dout: got frame, required none queued", i);
        end else begin
          ew = exp_q.pop_front();
          check($sformatf("vec%0d_dout_x", i), 32'(acc_x), 32'(ew[23:12]));
          check($sformatf("vec%0d_dout_y", i), 32'(acc_y), 32'(ew[11:0]));
        end
      end
      tick();
    end

    // ---------------- ack timeout ----------------
    drive(1'b1, 12'h0F0, 12'h00F, 1'b0, 1'b0);
    tick();
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 12'h7E1, 12'h18E, 1'b1, 1'b0);
    @(negedge clk);
    check("to_inready_start", 32'(bus.inReady), 1);
    tick();
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    acc_x = '0;
    for (int t = 3; t <= 33; t++) begin
      bus.VldIn = (t == 32);
      @(negedge clk);
      if (t == 23) begin
        check("to_state_last_wait", 32'(dbg_state), 32'(S_WAIT));
        check("to_ackerr_before", 32'(bus.AckErr), 0);
      end
      if (t == 24) begin
        check("to_state_abort", 32'(dbg_state), 32'(S_IDLE));
        check("to_ackerr_set", 32'(bus.AckErr), 1);
        check("to_rdy_abort", 32'(bus.Rdy), 0);
      end
      if (t == 25) begin
        check("to_next_rdy", 32'(bus.Rdy), 1);
        check("to_next_isout", 32'(bus.ISout), 1);
      end
      if (t >= 26 && t <= 31) acc_x = {bus.Xout, acc_x[11:2]};
      if (t == 32) check("to_next_dout_x", 32'(acc_x), 32'h7E1);
      if (t == 33) begin
        check("to_state_end", 32'(dbg_state), 32'(S_IDLE));
        check("to_ackerr_sticky", 32'(bus.AckErr), 1);
      end
      tick();
    end

    // ---------------- reset at SHIFT k=3 ----------------
    drive(1'b1, 12'hFFF, 12'hFFF, 1'b0, 1'b0);
    tick();
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 12'h0AA, 12'h055, 1'b1, 1'b0);
    tick();
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_xout_k3", 32'(bus.Xout), 3);
    check("rstmid_inready_low", 32'(bus.inReady), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_xout", 32'(bus.Xout), 0);
    check("rstmid_yout", 32'(bus.Yout), 0);
    check("rstmid_rdy", 32'(bus.Rdy), 0);
    check("rstmid_inready", 32'(bus.inReady), 1);
    check("rstmid_ackerr", 32'(bus.AckErr), 0);
    check("rstmid_isout", 32'(bus.ISout), 0);
    tick();
    for (int t = 8; t <= 12; t++) begin
      @(negedge clk);
      check($sformatf("rstmid_no_rdy_t%0d", t), 32'(bus.Rdy), 0);
      check($sformatf("rstmid_idle_t%0d", t), 32'(dbg_state), 32'(S_IDLE));
      tick();
    end

    // ---------------- three consecutive offers ----------------
    pend_q.push_back({1'b0, 12'h111, 12'h222});
    pend_q.push_back({1'b1, 12'h333, 12'h444});
    pend_q.push_back({1'b0, 12'h555, 12'h666});
    acc_x = '0;
    for (int t = 0; t <= 25; t++) begin
      if (pend_q.size() != 0)
        drive(1'b1, pend_q[0][23:12], pend_q[0][11:0], pend_q[0][24], (t == 9) || (t == 17) || (t == 25));
      else
        drive(1'b0, 12'h000, 12'h000, 1'b0, (t == 9) || (t == 17) || (t == 25));
      @(negedge clk);
      if (t == 1) check("ow_inready_c1", 32'(bus.inReady), 32'(OW));
      if (t == 2) check("ow_inready_c2", 32'(bus.inReady), 1);
      if (t == 3) check("ow_ovf_c3", 32'(bus.Ovf), 32'(OW));
      if ((t >= 3 && t <= 8) || (t >= 11 && t <= 16)) acc_x = {bus.Xout, acc_x[11:2]};
      if (t == 9) begin
        check("ow_frame1_x", 32'(acc_x), 32'h111);
        acc_x = '0;
      end
      if (t == 10) begin
        check("ow_frame2_rdy", 32'(bus.Rdy), 1);
        check("ow_frame2_isout", 32'(bus.ISout), OW ? 32'd0 : 32'd1);
      end
      if (t == 17) check("ow_frame2_x", 32'(acc_x), OW ? 32'h555 : 32'h333);
      if (t == 25) check("ow_ovf_end", 32'(bus.Ovf), 32'(OW));
      if (bus.inValid && bus.inReady) void'(pend_q.pop_front());
      tick();
    end
    check("ow_all_offers_taken", pend_q.size(), OW ? 32'd0 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
